mac_unit: RTL and testbench

MAC_UNIT -- requirements
Module: mac_unit

---
 rtl/mac_if.sv | 35 +++
 rtl/mac_unit.sv | 172 +++++++++++++++++
 tb/tb_mac_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_if.sv
// mac_unit request/result bundle.
// master drives operands, slave returns results.
interface mac_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mode;
  logic             set_flags;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, mode, set_flags,
    output op_a, op_b, acc_hi, acc_lo,
    input  busy, done,
    input  result_hi, result_lo,
    input  flag_n, flag_z
  );

  modport slave (
    input  start, mode, set_flags,
    input  op_a, op_b, acc_hi, acc_lo,
    output busy, done,
    output result_hi, result_lo,
    output flag_n, flag_z
  );
endinterface

// File: rtl/mac_unit.sv
// Iterative multiply-accumulate, STEP multiplier
// bits per cycle with early exit on zero.
module mac_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input logic clk,
  input logic reset_n,
  mac_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_step
    $error("mac_unit: STEP must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    FINISH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]       mode_q;
  logic             sf_q;
  logic [W2-1:0]    acc_q;
  logic             neg_q;
  logic [W2-1:0]    ma_q;
  logic [WIDTH-1:0] mb_q;
  logic [W2-1:0]    prod_q;

  logic             done_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;
  logic             fn_q;
  logic             fz_q;

  logic             accept;
  logic             in_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [STEP-1:0]  digit;
  logic [W2-1:0]    term;
  logic [WIDTH-1:0] mb_nxt;
  logic             last;

  logic             is_long;
  logic             long_acc;
  logic             short_acc;
  logic [W2-1:0]    full;
  logic [W2-1:0]    long_sum;
  logic [WIDTH-1:0] short_lo;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;
  logic             fin_n;
  logic             fin_z;

  assign accept = (state == IDLE) && bus.start;

  // Operand magnitudes; only SMULL/SMLAL are signed.
  always_comb begin
    in_signed = bus.mode[2] & bus.mode[1];
    a_neg     = in_signed & bus.op_a[WIDTH-1];
    b_neg     = in_signed & bus.op_b[WIDTH-1];
    mag_a     = a_neg ? -bus.op_a : bus.op_a;
    mag_b     = b_neg ? -bus.op_b : bus.op_b;
  end

  // One radix-2^STEP partial product per MULT cycle.
  always_comb begin
    digit  = mb_q[STEP-1:0];
    term   = ma_q * W2'(digit);
    mb_nxt = mb_q >> STEP;
    last   = (mb_nxt == '0);
  end

  // Sign fix-up, accumulate and flag generation.
  always_comb begin
    is_long   = mode_q[2];
    long_acc  = mode_q[2] & mode_q[0];
    short_acc = (mode_q == 3'd1);
    full      = neg_q ? -prod_q : prod_q;
    long_sum  = full + (long_acc ? acc_q : '0);
    short_lo  = full[WIDTH-1:0]
              + (short_acc ? acc_q[WIDTH-1:0] : '0);
    fin_hi    = is_long ? long_sum[W2-1:WIDTH] : '0;
    fin_lo    = is_long ? long_sum[WIDTH-1:0] : short_lo;
    fin_n     = is_long ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
    fin_z     = ({fin_hi, fin_lo} == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MULT;
      MULT:    if (last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    bus.busy = (state != IDLE);
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= '0;
      sf_q   <= 1'b0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
      prod_q <= '0;
    end else if (accept) begin
      mode_q <= bus.mode;
      sf_q   <= bus.set_flags;
      acc_q  <= {bus.acc_hi, bus.acc_lo};
      neg_q  <= a_neg ^ b_neg;
      ma_q   <= W2'(mag_a);
      mb_q   <= mag_b;
      prod_q <= '0;
    end else if (state == MULT) begin
      prod_q <= prod_q + term;
      ma_q   <= ma_q << STEP;
      mb_q   <= mb_nxt;
    end
  end

  // Result, flags and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
    end else begin
      done_q <= (state == FINISH);
      if (state == FINISH) begin
        res_hi_q <= fin_hi;
        res_lo_q <= fin_lo;
        if (sf_q) begin
          fn_q <= fin_n;
          fz_q <= fin_z;
        end
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;
  assign bus.flag_n    = fn_q;
  assign bus.flag_z    = fz_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit, WIDTH=32 STEP=8.
// Hand-computed vectors per scenario task.
module tb_mac_unit;

  logic clk;
  logic reset_n;
  int   checks;
  int   fails;

  mac_if #(.WIDTH(32)) bus ();

  mac_unit #(.WIDTH(32), .STEP(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request at negedge; returns #1 after accept edge.
  task automatic launch(input logic [2:0] m, input logic sf,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ah, input logic [31:0] al);
    @(negedge clk);
    bus.mode      = m;
    bus.set_flags = sf;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.acc_hi    = ah;
    bus.acc_lo    = al;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges until done is seen (#1 after each edge); -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.mode = '0; bus.set_flags = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    bus.acc_hi = '0; bus.acc_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'h0) begin
      fails++;
      $display("FAIL reset_res got %h want 0",
               {bus.result_hi, bus.result_lo});
    end
    checks++;
    if ({bus.flag_n, bus.flag_z} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags got %b want 00",
               {bus.flag_n, bus.flag_z});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat;
    launch(3'd0, 1'b1, 32'd7, 32'd6, 32'h0, 32'h0);
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL mul_busy got %b want 1", bus.busy);
    end
    wait_done(lat);
    checks++;
    if (lat != 2) begin
      fails++;
      $display("FAIL mul_lat got %0d want 2", lat);
    end
    checks++;
    if (bus.result_hi !== 32'h0 || bus.result_lo !== 32'h2A) begin
      fails++;
      $display("FAIL mul_res got %h_%h want 0_2a",
               bus.result_hi, bus.result_lo);
    end
    checks++;
    if ({bus.flag_n, bus.flag_z} !== 2'b00) begin
      fails++;
      $display("FAIL mul_flags got %b want 00",
               {bus.flag_n, bus.flag_z});
    end
    // Short mode with product wrapping to zero; code 3 acts as MUL.
    launch(3'd3, 1'b1, 32'h0001_0000, 32'h0001_0000,
           32'h5555_5555, 32'h1);
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      fails++;
      $display("FAIL mul3_lat got %0d want 4", lat);
    end
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'h0 ||
        {bus.flag_n, bus.flag_z} !== 2'b01) begin
      fails++;
      $display("FAIL mul3_res got %h nz=%b want 0 nz=01",
               {bus.result_hi, bus.result_lo},
               {bus.flag_n, bus.flag_z});
    end
  endtask

  task automatic test_mla();
    int lat;
    launch(3'd1, 1'b1, 32'd3, 32'd5, 32'h1234_5678, 32'hFFFF_FFF0);
    wait_done(lat);
    checks++;
    if (lat != 2) begin
      fails++;
      $display("FAIL mla_lat got %0d want 2", lat);
    end
    checks++;
    if (bus.result_hi !== 32'h0 || bus.result_lo !== 32'hFFFF_FFFF ||
        {bus.flag_n, bus.flag_z} !== 2'b10) begin
      fails++;
      $display("FAIL mla_res got %h_%h nz=%b want 0_ffffffff nz=10",
               bus.result_hi, bus.result_lo,
               {bus.flag_n, bus.flag_z});
    end
  endtask

  task automatic test_umlal();
    int lat;
    launch(3'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    wait_done(lat);
    checks++;
    if (lat != 5) begin
      fails++;
      $display("FAIL umlal_lat got %0d want 5", lat);
    end
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFE_0000_0002) begin
      fails++;
      $display("FAIL umlal_res got %h want fffffffe00000002",
               {bus.result_hi, bus.result_lo});
    end
    checks++;
    if ({bus.flag_n, bus.flag_z} !== 2'b10) begin
      fails++;
      $display("FAIL umlal_flags got %b want 10",
               {bus.flag_n, bus.flag_z});
    end
  endtask

  task automatic test_smull();
    int lat;
    launch(3'd6, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
    wait_done(lat);
    checks++;
    if (lat != 2) begin
      fails++;
      $display("FAIL smull1_lat got %0d want 2", lat);
    end
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFFA ||
        bus.flag_n !== 1'b1) begin
      fails++;
      $display("FAIL smull1_res got %h n=%b want fffffffffffffffa n=1",
               {bus.result_hi, bus.result_lo}, bus.flag_n);
    end
    launch(3'd6, 1'b1, 32'd1, 32'h8000_0000, 32'h0, 32'h0);
    wait_done(lat);
    checks++;
    if (lat != 5) begin
      fails++;
      $display("FAIL smull2_lat got %0d want 5", lat);
    end
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_8000_0000) begin
      fails++;
      $display("FAIL smull2_res got %h want ffffffff80000000",
               {bus.result_hi, bus.result_lo});
    end
  endtask

  task automatic test_smlal_flags();
    int lat;
    launch(3'd7, 1'b1, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'h0 ||
        {bus.flag_n, bus.flag_z} !== 2'b01) begin
      fails++;
      $display("FAIL smlal_zero got %h nz=%b want 0 nz=01",
               {bus.result_hi, bus.result_lo},
               {bus.flag_n, bus.flag_z});
    end
    launch(3'd7, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    wait_done(lat);
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFFE ||
        {bus.flag_n, bus.flag_z} !== 2'b01) begin
      fails++;
      $display("FAIL smlal_hold got %h nz=%b want fffffffffffffffe nz=01",
               {bus.result_hi, bus.result_lo},
               {bus.flag_n, bus.flag_z});
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int extra;
    launch(3'd4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    bus.start = 1'b1;
    bus.mode  = 3'd0;
    bus.op_a  = 32'd1;
    bus.op_b  = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      fails++;
      $display("FAIL busy_lat got %0d want 4", lat);
    end
    checks++;
    if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFE_0000_0001) begin
      fails++;
      $display("FAIL busy_res got %h want fffffffe00000001",
               {bus.result_hi, bus.result_lo});
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      fails++;
      $display("FAIL busy_queue got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(3'd0, 1'b1, 32'd4, 32'd5, 32'h0, 32'h0);
    wait_done(lat);
    checks++;
    if (bus.result_lo !== 32'd20 || lat != 2) begin
      fails++;
      $display("FAIL b2b_first got %0d lat=%0d want 20 lat=2",
               bus.result_lo, lat);
    end
    bus.op_a  = 32'd9;
    bus.op_b  = 32'd9;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept busy=%b want 1", bus.busy);
    end
    wait_done(lat);
    checks++;
    if (bus.result_lo !== 32'd81 || lat != 2) begin
      fails++;
      $display("FAIL b2b_second got %0d lat=%0d want 81 lat=2",
               bus.result_lo, lat);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    launch(3'd4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        {bus.result_hi, bus.result_lo} !== 64'h0 ||
        {bus.flag_n, bus.flag_z} !== 2'b00) begin
      fails++;
      $display("FAIL abort_async busy=%b done=%b res=%h nz=%b want all 0",
               bus.busy, bus.done, {bus.result_hi, bus.result_lo},
               {bus.flag_n, bus.flag_z});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_done got %0d pulses want 0", seen);
    end
    launch(3'd0, 1'b1, 32'd2, 32'd3, 32'h0, 32'h0);
    wait_done(lat);
    checks++;
    if (lat != 2 || bus.result_lo !== 32'd6 || bus.result_hi !== 32'd0) begin
      fails++;
      $display("FAIL abort_after got %h_%h lat=%0d want 0_6 lat=2",
               bus.result_hi, bus.result_lo, lat);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_mul();
    test_mla();
    test_umlal();
    test_smull();
    test_smlal_flags();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
